// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the Datapath.
// SINGLE_STEP_EN adds the step request line.
interface control_sequencer_if;
   logic        start;
   logic [31:0] ir;
`ifdef SINGLE_STEP_EN
   logic        step;
`endif
   logic ctl_pcout, ctl_marin, ctl_incpc, ctl_zlowin, ctl_zlowout, ctl_pcin;
   logic ctl_mdmuxread, ctl_ramread, ctl_ramwrite, ctl_mdrin, ctl_mdrout, ctl_irin;
   logic ctl_gra, ctl_grb, ctl_grc, ctl_rin, ctl_rout, ctl_baout, ctl_yin, ctl_cseout;
   logic op_add, op_sub, op_and, op_or, op_neg, op_not;
   logic run, illegal;

   modport master (
`ifdef SINGLE_STEP_EN
      input  step,
`endif
      input  start, ir,
      output ctl_pcout, ctl_marin, ctl_incpc, ctl_zlowin, ctl_zlowout, ctl_pcin,
             ctl_mdmuxread, ctl_ramread, ctl_ramwrite, ctl_mdrin, ctl_mdrout, ctl_irin,
             ctl_gra, ctl_grb, ctl_grc, ctl_rin, ctl_rout, ctl_baout, ctl_yin, ctl_cseout,
             op_add, op_sub, op_and, op_or, op_neg, op_not, run, illegal
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      output step,
`endif
      output start, ir,
      input  ctl_pcout, ctl_marin, ctl_incpc, ctl_zlowin, ctl_zlowout, ctl_pcin,
             ctl_mdmuxread, ctl_ramread, ctl_ramwrite, ctl_mdrin, ctl_mdrout, ctl_irin,
             ctl_gra, ctl_grb, ctl_grc, ctl_rin, ctl_rout, ctl_baout, ctl_yin, ctl_cseout,
             op_add, op_sub, op_and, op_or, op_neg, op_not, run, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit; Moore outputs registered from the next state.
// SINGLE_STEP_EN: adds PAUSE after every instruction, released by bus.step.
module control_sequencer #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned OP_LSB   = 27
) (
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);
   localparam int unsigned OP_W   = 5;
   localparam int unsigned WAIT_W = 2;

   localparam logic [OP_W-1:0] OPC_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OPC_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OPC_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OPC_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OPC_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OPC_AND  = 5'b01010;
   localparam logic [OP_W-1:0] OPC_OR   = 5'b01011;
   localparam logic [OP_W-1:0] OPC_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OPC_ANDI = 5'b01101;
   localparam logic [OP_W-1:0] OPC_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OPC_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OPC_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OPC_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OPC_HALT = 5'b11011;

   // R*: register/immediate ALU, L*: address/ldi path, M5: MAR load, U3: unary, WB: Z -> Ra
   typedef enum logic [4:0] {
      S_IDLE, S_HALT,
`ifdef SINGLE_STEP_EN
      S_PAUSE,
`endif
      S_T0, S_T1, S_T2, S_R3, S_R4, S_I4, S_WB, S_L3, S_L4, S_M5,
      S_LD6, S_LD7, S_ST6, S_ST7, S_U3, S_ILL
   } state_t;

   typedef struct packed {
      logic pcout, marin, incpc, zlowin, zlowout, pcin;
      logic mdmuxread, ramread, ramwrite, mdrin, mdrout, irin;
      logic gra, grb, grc, rin, rout, baout, yin, cseout;
      logic op_add, op_sub, op_and, op_or, op_neg, op_not;
      logic run, illegal;
   } ctl_t;

   state_t            r_state, w_state_n, w_last;
   logic [OP_W-1:0]   r_opc, w_opc_n, w_opc_ir;
   logic [WAIT_W-1:0] r_wait, w_wait_n;
   ctl_t              r_ctl, w_ctl_n;
   logic              w_alu;
   logic              w_unused_ir;

   assign w_opc_ir    = bus.ir[OP_LSB +: OP_W];
   assign w_unused_ir = ^bus.ir;

`ifdef SINGLE_STEP_EN
   assign w_last = S_PAUSE;
`else
   assign w_last = S_T0;
`endif

   // Next state, latched opcode and memory-wait counter
   always_comb begin
      w_state_n = r_state;
      w_opc_n   = r_opc;
      w_wait_n  = '0;
      case (r_state)
         S_IDLE, S_HALT: if (bus.start) w_state_n = S_T0;
`ifdef SINGLE_STEP_EN
         S_PAUSE:        if (bus.step) w_state_n = S_T0;
`endif
         S_T0:           w_state_n = S_T1;
         S_T1, S_LD6: begin
            if (r_wait < WAIT_W'(MEM_WAIT)) w_wait_n = r_wait + WAIT_W'(1);
            else w_state_n = (r_state == S_T1) ? S_T2 : S_LD7;
         end
         S_T2: begin
            w_opc_n = w_opc_ir;
            case (w_opc_ir)
               OPC_LD, OPC_LDI, OPC_ST:                    w_state_n = S_L3;
               OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
               OPC_ADDI, OPC_ANDI, OPC_ORI:                w_state_n = S_R3;
               OPC_NEG, OPC_NOT:                           w_state_n = S_U3;
               OPC_NOP:                                    w_state_n = w_last;
               OPC_HALT:                                   w_state_n = S_HALT;
               default:                                    w_state_n = S_ILL;
            endcase
         end
         S_R3: w_state_n = (r_opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR}) ? S_R4 : S_I4;
         S_R4, S_I4, S_U3: w_state_n = S_WB;
         S_L3:  w_state_n = S_L4;
         S_L4:  w_state_n = (r_opc == OPC_LDI) ? S_WB : S_M5;
         S_M5:  w_state_n = (r_opc == OPC_LD) ? S_LD6 : S_ST6;
         S_ST6: w_state_n = S_ST7;
         S_WB, S_LD7, S_ST7, S_ILL: w_state_n = w_last;
         default: w_state_n = S_IDLE;
      endcase
   end

   // Output decode of the state being entered
   always_comb begin
      w_ctl_n = '0;
      w_alu   = 1'b0;
      case (w_state_n)
         S_T0:  begin w_ctl_n.pcout = 1'b1; w_ctl_n.marin = 1'b1;
                      w_ctl_n.incpc = 1'b1; w_ctl_n.zlowin = 1'b1; end
         S_T1:  begin w_ctl_n.zlowout = 1'b1; w_ctl_n.mdmuxread = 1'b1;
                      w_ctl_n.ramread = 1'b1; w_ctl_n.mdrin = 1'b1;
                      w_ctl_n.pcin = (w_wait_n == WAIT_W'(MEM_WAIT)); end
         S_T2:  begin w_ctl_n.mdrout = 1'b1; w_ctl_n.irin = 1'b1; end
         S_R3:  begin w_ctl_n.grb = 1'b1; w_ctl_n.rout = 1'b1; w_ctl_n.yin = 1'b1; end
         S_R4:  begin w_ctl_n.grc = 1'b1; w_ctl_n.rout = 1'b1; w_ctl_n.zlowin = 1'b1; w_alu = 1'b1; end
         S_I4, S_L4: begin w_ctl_n.cseout = 1'b1; w_ctl_n.zlowin = 1'b1; w_alu = 1'b1; end
         S_U3:  begin w_ctl_n.grb = 1'b1; w_ctl_n.rout = 1'b1; w_ctl_n.zlowin = 1'b1; w_alu = 1'b1; end
         S_WB:  begin w_ctl_n.zlowout = 1'b1; w_ctl_n.gra = 1'b1; w_ctl_n.rin = 1'b1; end
         S_L3:  begin w_ctl_n.grb = 1'b1; w_ctl_n.baout = 1'b1; w_ctl_n.yin = 1'b1; end
         S_M5:  begin w_ctl_n.zlowout = 1'b1; w_ctl_n.marin = 1'b1; end
         S_LD6: begin w_ctl_n.mdmuxread = 1'b1; w_ctl_n.ramread = 1'b1; w_ctl_n.mdrin = 1'b1; end
         S_LD7: begin w_ctl_n.mdrout = 1'b1; w_ctl_n.gra = 1'b1; w_ctl_n.rin = 1'b1; end
         S_ST6: begin w_ctl_n.gra = 1'b1; w_ctl_n.rout = 1'b1; w_ctl_n.mdrin = 1'b1; end
         S_ST7: w_ctl_n.ramwrite = 1'b1;
         S_ILL: w_ctl_n.illegal = 1'b1;
         default: ;
      endcase
      // Address arithmetic for ld/ldi/st and the immediates reuse the adder
      if (w_alu) begin
         case (w_opc_n)
            OPC_ADD, OPC_ADDI, OPC_LD, OPC_LDI, OPC_ST: w_ctl_n.op_add = 1'b1;
            OPC_SUB:                                    w_ctl_n.op_sub = 1'b1;
            OPC_AND, OPC_ANDI:                          w_ctl_n.op_and = 1'b1;
            OPC_OR, OPC_ORI:                            w_ctl_n.op_or  = 1'b1;
            OPC_NEG:                                    w_ctl_n.op_neg = 1'b1;
            OPC_NOT:                                    w_ctl_n.op_not = 1'b1;
            default: ;
         endcase
      end
      w_ctl_n.run = (w_state_n != S_IDLE) && (w_state_n != S_HALT)
`ifdef SINGLE_STEP_EN
                    && (w_state_n != S_PAUSE)
`endif
                    ;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
         r_opc   <= '0;
         r_wait  <= '0;
         r_ctl   <= '0;
      end else begin
         r_state <= w_state_n;
         r_opc   <= w_opc_n;
         r_wait  <= w_wait_n;
         r_ctl   <= w_ctl_n;
      end
   end

   assign bus.ctl_pcout     = r_ctl.pcout;
   assign bus.ctl_marin     = r_ctl.marin;
   assign bus.ctl_incpc     = r_ctl.incpc;
   assign bus.ctl_zlowin    = r_ctl.zlowin;
   assign bus.ctl_zlowout   = r_ctl.zlowout;
   assign bus.ctl_pcin      = r_ctl.pcin;
   assign bus.ctl_mdmuxread = r_ctl.mdmuxread;
   assign bus.ctl_ramread   = r_ctl.ramread;
   assign bus.ctl_ramwrite  = r_ctl.ramwrite;
   assign bus.ctl_mdrin     = r_ctl.mdrin;
   assign bus.ctl_mdrout    = r_ctl.mdrout;
   assign bus.ctl_irin      = r_ctl.irin;
   assign bus.ctl_gra       = r_ctl.gra;
   assign bus.ctl_grb       = r_ctl.grb;
   assign bus.ctl_grc       = r_ctl.grc;
   assign bus.ctl_rin       = r_ctl.rin;
   assign bus.ctl_rout      = r_ctl.rout;
   assign bus.ctl_baout     = r_ctl.baout;
   assign bus.ctl_yin       = r_ctl.yin;
   assign bus.ctl_cseout    = r_ctl.cseout;
   assign bus.op_add        = r_ctl.op_add;
   assign bus.op_sub        = r_ctl.op_sub;
   assign bus.op_and        = r_ctl.op_and;
   assign bus.op_or         = r_ctl.op_or;
   assign bus.op_neg        = r_ctl.op_neg;
   assign bus.op_not        = r_ctl.op_not;
   assign bus.run           = r_ctl.run;
   assign bus.illegal       = r_ctl.illegal;
endmodule
